// File: rtl/rpsc_pkg.sv
// Shared types and constants for the RPSC fault/interlock card.
package rpsc_pkg;

  // Per-channel fault state.
  typedef enum logic [1:0] {
    CH_HEALTHY   = 2'd0,
    CH_DEBOUNCE  = 2'd1,
    CH_LATCHED   = 2'd2,
    CH_CLEARABLE = 2'd3
  } ch_state_t;

  // Depth of every input synchroniser on the card.
  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/rpsc_fault_ch.sv
// One fault channel: input synchroniser, debounce counter, latch FSM.
// ok_o is 1 while the channel is healthy or debouncing.
// latch_entry_o flags the edge on which the channel moves into CH_LATCHED.
module rpsc_fault_ch
  import rpsc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic ch_in,
  input  logic ack_rise,
  output logic ok_o,
  output logic latch_entry_o
);

  localparam int unsigned   CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LIM = CW'(DEB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   in_sync;
  logic [CW-1:0]          cnt_q, cnt_d;
  ch_state_t              state_q, state_d;

  // Field input synchroniser; idles healthy (1) out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ch_in};
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  // State and debounce counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CH_HEALTHY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: debounce on the way in, acknowledge on the way out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CH_HEALTHY: begin
        if (!in_sync) begin
          cnt_d   = CW'(1);
          state_d = (DEB_CYCLES == 1) ? CH_LATCHED : CH_DEBOUNCE;
        end
      end
      CH_DEBOUNCE: begin
        if (in_sync) begin
          state_d = CH_HEALTHY;
          cnt_d   = '0;
        end else begin
          if (cnt_q != DEB_LIM) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (cnt_q == DEB_LIM - CW'(1)) begin
            state_d = CH_LATCHED;
          end
        end
      end
      CH_LATCHED: begin
        if (in_sync) begin
          state_d = CH_CLEARABLE;
        end
      end
      CH_CLEARABLE: begin
        // A returning fault takes priority over a simultaneous acknowledge.
        if (!in_sync) begin
          state_d = CH_LATCHED;
        end else if (ack_rise) begin
          state_d = CH_HEALTHY;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CH_HEALTHY;
        cnt_d   = '0;
      end
    endcase
  end

  assign ok_o          = (state_q == CH_HEALTHY) || (state_q == CH_DEBOUNCE);
  assign latch_entry_o = (state_d == CH_LATCHED) && (state_q != CH_LATCHED);

endmodule

// File: rtl/rpsc_fault_card.sv
// N-channel fault/interlock card: per-channel latches, summary trip,
// lamp panel drive with lamp test, and optional first-out capture.
// Optional feature macro: RPSC_FIRST_OUT_EN (first-out capture and
// blinking first-out lamp). Without it the first-out outputs read 0 and
// every faulted lamp is steady.
module rpsc_fault_card
  import rpsc_pkg::*;
#(
  parameter int unsigned N_CH       = 8,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned BLINK_HALF = 2_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH-1:0]           ch_in,
  input  logic                      ack,
  input  logic                      la_test,
  output logic [N_CH-1:0]           ch_ok,
  output logic [N_CH-1:0]           ch_lamp,
  output logic                      trip,
  output logic [$clog2(N_CH)-1:0]   first_out_id,
  output logic                      first_out_valid
);

  localparam int unsigned IDW = $clog2(N_CH);

  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [SYNC_STAGES-1:0] la_sync_q;
  logic                   ack_prev_q;
  logic                   ack_rise;
  logic                   la_on;
  logic [N_CH-1:0]        entry;
  logic [N_CH-1:0]        faulted;

  // Operator input synchronisers plus the delayed ack used for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_sync_q <= '0;
      la_sync_q  <= '0;
      ack_prev_q <= 1'b0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack};
      la_sync_q  <= {la_sync_q[SYNC_STAGES-2:0], la_test};
      ack_prev_q <= ack_sync_q[SYNC_STAGES-1];
    end
  end

  assign ack_rise = ack_sync_q[SYNC_STAGES-1] & ~ack_prev_q;
  assign la_on    = la_sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rpsc_fault_ch #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .ch_in        (ch_in[g]),
      .ack_rise     (ack_rise),
      .ok_o         (ch_ok[g]),
      .latch_entry_o(entry[g])
    );
  end

  assign faulted = ~ch_ok;
  assign trip    = |faulted;

`ifdef RPSC_FIRST_OUT_EN

  localparam int unsigned    BW         = $clog2(BLINK_HALF);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic [IDW-1:0]  fo_id_q, fo_id_d;
  logic            fo_valid_q, fo_valid_d;
  logic [IDW-1:0]  lowest_entry;
  logic [N_CH-1:0] blink_off;

  // Blink generator: phase toggles every BLINK_HALF cycles, starting dark.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Blink generator registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Lowest-index channel entering CH_LATCHED this edge (scan high to low so
  // the last hit wins).
  always_comb begin
    lowest_entry = '0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (entry[i-1]) begin
        lowest_entry = IDW'(i - 1);
      end
    end
  end

  // First-out capture: armed while invalid, released once trip has cleared.
  always_comb begin
    fo_id_d    = fo_id_q;
    fo_valid_d = fo_valid_q;
    if (fo_valid_q) begin
      if (!trip) begin
        fo_valid_d = 1'b0;
      end
    end else if (|entry) begin
      fo_valid_d = 1'b1;
      fo_id_d    = lowest_entry;
    end
  end

  // First-out registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fo_id_q    <= '0;
      fo_valid_q <= 1'b0;
    end else begin
      fo_id_q    <= fo_id_d;
      fo_valid_q <= fo_valid_d;
    end
  end

  // Darken the first-out lamp during the off half of the blink period.
  always_comb begin
    blink_off = '0;
    if (fo_valid_q && !blink_phase_q) begin
      blink_off[fo_id_q] = 1'b1;
    end
  end

  assign first_out_id    = fo_id_q;
  assign first_out_valid = fo_valid_q;
  assign ch_lamp         = (faulted & ~blink_off) | {N_CH{la_on}};

`else

  logic unused_entry;
  assign unused_entry = ^entry;

  assign first_out_id    = '0;
  assign first_out_valid = 1'b0;
  assign ch_lamp         = faulted | {N_CH{la_on}};

`endif

endmodule

// File: tb/tb_rpsc_fault_card.sv
// Bench for rpsc_fault_card with N_CH=8, DEB_CYCLES=4, BLINK_HALF=8.
module tb_rpsc_fault_card;

  localparam int unsigned BH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ch_in;
  logic       ack;
  logic       la_test;
  logic [7:0] ch_ok;
  logic [7:0] ch_lamp;
  logic       trip;
  logic [2:0] first_out_id;
  logic       first_out_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0]  ch;
    logic        ack;
    logic        la;
    int unsigned n;
    logic [7:0]  ok;
    logic        trip;
    logic [2:0]  fid;
    logic        fv;
    logic        la_on;
  } vec_t;

  typedef struct {
    logic [7:0] ok;
    logic       trip;
    logic [2:0] fid;
    logic       fv;
    logic       la_on;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  rpsc_fault_card #(
    .N_CH      (8),
    .DEB_CYCLES(4),
    .BLINK_HALF(BH)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .ch_in          (ch_in),
    .ack            (ack),
    .la_test        (la_test),
    .ch_ok          (ch_ok),
    .ch_lamp        (ch_lamp),
    .trip           (trip),
    .first_out_id   (first_out_id),
    .first_out_valid(first_out_valid)
  );

  always #5 clk = ~clk;

  // Edges since reset release; drives the bench's view of the blink phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [7:0] ch, input logic a, input logic la,
                              input int unsigned n, input logic [7:0] ok,
                              input logic tr, input logic [2:0] fid,
                              input logic fv, input logic la_on);
    vec_t v;
    v.ch = ch; v.ack = a; v.la = la; v.n = n; v.ok = ok;
    v.trip = tr; v.fid = fid; v.fv = fv; v.la_on = la_on;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check(input exp_t e, input string tag);
    logic [7:0] lamp_e;
    logic [2:0] fid_e;
    logic       fv_e;
    lamp_e = ~e.ok;
`ifdef RPSC_FIRST_OUT_EN
    fid_e = e.fid;
    fv_e  = e.fv;
    if (e.fv && (((cyc / BH) % 2) == 0)) lamp_e[e.fid] = 1'b0;
`else
    fid_e = 3'd0;
    fv_e  = 1'b0;
`endif
    if (e.la_on) lamp_e = 8'hFF;
    cmp({tag, " ch_ok"},   ch_ok,                  e.ok);
    cmp({tag, " ch_lamp"}, ch_lamp,                lamp_e);
    cmp({tag, " trip"},    {7'd0, trip},           {7'd0, e.trip});
    cmp({tag, " fo_id"},   {5'd0, first_out_id},   {5'd0, fid_e});
    cmp({tag, " fo_valid"},{7'd0, first_out_valid},{7'd0, fv_e});
  endtask

  // Drive at a falling edge, wait v.n rising edges, sample at the next fall.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    ch_in   = v.ch;
    ack     = v.ack;
    la_test = v.la;
    e.ok = v.ok; e.trip = v.trip; e.fid = v.fid; e.fv = v.fv; e.la_on = v.la_on;
    sb.push_back(e);
    repeat (v.n) @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check(e, tag);
    end
  endtask

  initial begin
    exp_t er;

    // Reset and glitch rejection
    tbl.push_back(mk(8'hFF, 0, 0, 2, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(8'hFB, 0, 0, 3, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(8'hFF, 0, 0, 6, 8'hFF, 0, 0, 0, 0));
    // ch2 held low: one edge short, then latched at edge 6
    tbl.push_back(mk(8'hFB, 0, 0, 5, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(8'hFB, 0, 0, 1, 8'hFB, 1, 2, 1, 0));
    // Restore, acknowledge: clear at edge 3, valid drops one edge later
    tbl.push_back(mk(8'hFF, 0, 0, 3, 8'hFB, 1, 2, 1, 0));
    tbl.push_back(mk(8'hFF, 1, 0, 2, 8'hFB, 1, 2, 1, 0));
    tbl.push_back(mk(8'hFF, 1, 0, 1, 8'hFF, 0, 2, 1, 0));
    tbl.push_back(mk(8'hFF, 0, 0, 1, 8'hFF, 0, 2, 0, 0));
    // ch3 and ch5 together: lowest index wins, ch3 lamp blinks
    tbl.push_back(mk(8'hD7, 0, 0, 5, 8'hFF, 0, 2, 0, 0));
    tbl.push_back(mk(8'hD7, 0, 0, 1, 8'hD7, 1, 3, 1, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(8'hD7, 0, 0, 4, 8'hD7, 1, 3, 1, 0));
    // ack while still faulted is ignored
    tbl.push_back(mk(8'hD7, 1, 0, 3, 8'hD7, 1, 3, 1, 0));
    tbl.push_back(mk(8'hD7, 0, 0, 1, 8'hD7, 1, 3, 1, 0));
    // Restore ch3 only, ack clears it; first-out holds
    tbl.push_back(mk(8'hDF, 0, 0, 3, 8'hD7, 1, 3, 1, 0));
    tbl.push_back(mk(8'hDF, 1, 0, 3, 8'hDF, 1, 3, 1, 0));
    tbl.push_back(mk(8'hDF, 0, 0, 1, 8'hDF, 1, 3, 1, 0));
    // Clear ch5 too
    tbl.push_back(mk(8'hFF, 0, 0, 3, 8'hDF, 1, 3, 1, 0));
    tbl.push_back(mk(8'hFF, 1, 0, 3, 8'hFF, 0, 3, 1, 0));
    tbl.push_back(mk(8'hFF, 0, 0, 1, 8'hFF, 0, 3, 0, 0));
    // Lamp test: lamps follow after edge 2 both ways
    tbl.push_back(mk(8'hFF, 0, 1, 1, 8'hFF, 0, 3, 0, 0));
    tbl.push_back(mk(8'hFF, 0, 1, 1, 8'hFF, 0, 3, 0, 1));
    tbl.push_back(mk(8'hFF, 0, 0, 1, 8'hFF, 0, 3, 0, 1));
    tbl.push_back(mk(8'hFF, 0, 0, 1, 8'hFF, 0, 3, 0, 0));
    // ch1: clearable, input falls with the ack edge -> relatched
    tbl.push_back(mk(8'hFD, 0, 0, 6, 8'hFD, 1, 1, 1, 0));
    tbl.push_back(mk(8'hFF, 0, 0, 3, 8'hFD, 1, 1, 1, 0));
    tbl.push_back(mk(8'hFD, 1, 0, 3, 8'hFD, 1, 1, 1, 0));
    tbl.push_back(mk(8'hFD, 1, 0, 3, 8'hFD, 1, 1, 1, 0));
    tbl.push_back(mk(8'hFD, 0, 0, 2, 8'hFD, 1, 1, 1, 0));
    // Entering clearable on the ack-edge cycle is not cleared
    tbl.push_back(mk(8'hFF, 1, 0, 4, 8'hFD, 1, 1, 1, 0));
    tbl.push_back(mk(8'hFF, 0, 0, 2, 8'hFD, 1, 1, 1, 0));
    tbl.push_back(mk(8'hFF, 1, 0, 3, 8'hFF, 0, 1, 1, 0));
    tbl.push_back(mk(8'hFF, 0, 0, 1, 8'hFF, 0, 1, 0, 0));
    // Latch ch1 ahead of the mid-operation reset
    tbl.push_back(mk(8'hFD, 0, 0, 6, 8'hFD, 1, 1, 1, 0));

    rst_n   = 1'b0;
    ch_in   = 8'hFF;
    ack     = 1'b0;
    la_test = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted mid-latch: outputs return at once, without a clock edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    er.ok = 8'hFF; er.trip = 1'b0; er.fid = 3'd0; er.fv = 1'b0; er.la_on = 1'b0;
    check(er, "async_reset");
    repeat (2) @(negedge clk);
    check(er, "reset_hold");
    rst_n = 1'b1;

    // Still-faulted input re-latches 2+DEB_CYCLES edges after release
    run_vec(mk(8'hFD, 0, 0, 5, 8'hFF, 0, 0, 0, 0), "relatch_early");
    run_vec(mk(8'hFD, 0, 0, 1, 8'hFD, 1, 1, 1, 0), "relatch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
